// File: rtl/imem_loader.sv
// Boot loader: assembles little-endian words from a byte stream, writes instruction memory, then releases the core.
// Optional checksum byte check after the image is enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int DEPTH = 64,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  output logic          rx_ready,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [31:0]   wr_data,
  output logic          cpu_run,
  output logic          busy,
  output logic          error,
  output logic [AW-1:0] words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN   = 3'd1,
    S_DATA  = 3'd2,
    S_WRITE = 3'd3,
`ifdef IMEM_LOADER_CHECKSUM_EN
    S_CSUM  = 3'd4,
`endif
    S_DONE  = 3'd5,
    S_ERROR = 3'd6
  } state_e;

  localparam logic [7:0] DEPTH_B = 8'(DEPTH);

  state_e        state_q, state_d;
  logic [1:0]    byte_idx_q;
  logic [23:0]   word_q;
  logic [AW-1:0] n_q;
  logic [AW-1:0] words_q;
  logic [AW-1:0] wr_addr_q;
  logic [31:0]   wr_data_q;
  logic          rx_ready_q, wr_en_q, cpu_run_q, busy_q, error_q;
  logic          xfer_s, restart_s;
  logic [AW-1:0] count_inc_s;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]    csum_q;

  function automatic logic [7:0] csum_update(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction
`endif

  assign xfer_s      = rx_valid && rx_ready_q;
  assign restart_s   = start && ((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERROR));
  assign count_inc_s = words_q + AW'(1'b1);

  // Next-state selection
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) state_d = S_LEN;
        else       state_d = state_q;
      end
      S_LEN: begin
        if (!xfer_s)                 state_d = S_LEN;
        else if (rx_data == 8'd0)    state_d = S_DONE;
        else if (rx_data > DEPTH_B)  state_d = S_ERROR;
        else                         state_d = S_DATA;
      end
      S_DATA: begin
        if (xfer_s && (byte_idx_q == 2'd3)) state_d = S_WRITE;
        else                                state_d = S_DATA;
      end
      S_WRITE: begin
        if (count_inc_s == n_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_d = S_CSUM;
`else
          state_d = S_DONE;
`endif
        end else begin
          state_d = S_DATA;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (!xfer_s)                state_d = S_CSUM;
        else if (rx_data == csum_q) state_d = S_DONE;
        else                        state_d = S_ERROR;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // State, registered status outputs and datapath
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      rx_ready_q <= 1'b0;
      wr_en_q    <= 1'b0;
      cpu_run_q  <= 1'b0;
      busy_q     <= 1'b0;
      error_q    <= 1'b0;
      byte_idx_q <= 2'd0;
      word_q     <= 24'd0;
      n_q        <= '0;
      words_q    <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= 32'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q     <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      // Status flags follow the state being entered, so they are valid in that state's first cycle
`ifdef IMEM_LOADER_CHECKSUM_EN
      rx_ready_q <= (state_d == S_LEN) || (state_d == S_DATA) || (state_d == S_CSUM);
      busy_q     <= (state_d == S_LEN) || (state_d == S_DATA) || (state_d == S_WRITE) ||
                    (state_d == S_CSUM);
`else
      rx_ready_q <= (state_d == S_LEN) || (state_d == S_DATA);
      busy_q     <= (state_d == S_LEN) || (state_d == S_DATA) || (state_d == S_WRITE);
`endif
      wr_en_q   <= (state_d == S_WRITE);
      cpu_run_q <= (state_d == S_DONE);
      error_q   <= (state_d == S_ERROR);

      if (restart_s) begin
        words_q    <= '0;
        byte_idx_q <= 2'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_q     <= 8'd0;
`endif
      end else if (state_q == S_LEN && xfer_s) begin
        n_q <= AW'(rx_data);
      end else if (state_q == S_DATA && xfer_s) begin
        byte_idx_q <= byte_idx_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_q     <= csum_update(csum_q, rx_data);
`endif
        case (byte_idx_q)
          2'd0: word_q[7:0]   <= rx_data;
          2'd1: word_q[15:8]  <= rx_data;
          2'd2: word_q[23:16] <= rx_data;
          2'd3: begin
            wr_data_q <= {rx_data, word_q};
            wr_addr_q <= words_q;
          end
          default: word_q <= word_q;
        endcase
      end else if (state_q == S_WRITE) begin
        words_q <= count_inc_s;
      end
    end
  end

  assign rx_ready     = rx_ready_q;
  assign wr_en        = wr_en_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign cpu_run      = cpu_run_q;
  assign busy         = busy_q;
  assign error        = error_q;
  assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader; checksum bytes are sent only when IMEM_LOADER_CHECKSUM_EN is defined.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset, start, rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready, wr_en, cpu_run, busy, error;
  logic [7:0]  wr_addr, words_loaded;
  logic [31:0] wr_data;

  int n_checks = 0;
  int n_fail   = 0;
  int wr_cnt   = 0;
  int base;
  logic [31:0] mem_model [64];

  always #5 clk = ~clk;

  imem_loader dut (
    .clk(clk), .reset(reset), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cpu_run(cpu_run), .busy(busy), .error(error), .words_loaded(words_loaded)
  );

  // Record every memory write strobe
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      wr_cnt = wr_cnt + 1;
      mem_model[wr_addr[5:0]] = wr_data;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    while (rx_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) check_eq("rx_ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic finish_load(input logic [7:0] csum);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(csum);
`else
    if (csum == 8'hFF) check_eq("csum_tag", 32'(csum), 32'd0);
    idle_cycle();
`endif
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'd0;
    repeat (2) @(negedge clk);
    check_eq("rst_rx_ready", 32'(rx_ready), 32'd0);
    check_eq("rst_wr_en",    32'(wr_en),    32'd0);
    check_eq("rst_cpu_run",  32'(cpu_run),  32'd0);
    check_eq("rst_busy",     32'(busy),     32'd0);
    check_eq("rst_error",    32'(error),    32'd0);
    check_eq("rst_words",    32'(words_loaded), 32'd0);
    check_eq("rst_wr_addr",  32'(wr_addr),  32'd0);
    check_eq("rst_wr_data",  wr_data,       32'd0);
    reset = 1'b0;
    idle_cycle();
    check_eq("idle_rx_ready", 32'(rx_ready), 32'd0);

    // Two-word image at full rate
    base = wr_cnt;
    pulse_start();
    check_eq("t1_busy_after_start", 32'(busy), 32'd1);
    check_eq("t1_ready_in_len", 32'(rx_ready), 32'd1);
    send_byte(8'h02);
    send_word(32'h00007033);
    check_eq("t1_w0_wr_en", 32'(wr_en), 32'd1);
    check_eq("t1_w0_addr", 32'(wr_addr), 32'd0);
    check_eq("t1_w0_data", wr_data, 32'h00007033);
    check_eq("t1_write_no_ready", 32'(rx_ready), 32'd0);
    send_word(32'h00100093);
    check_eq("t1_w1_wr_en", 32'(wr_en), 32'd1);
    check_eq("t1_w1_addr", 32'(wr_addr), 32'd1);
    check_eq("t1_w1_data", wr_data, 32'h00100093);
    check_eq("t1_cpu_held", 32'(cpu_run), 32'd0);
    finish_load(8'hC0);
    check_eq("t1_cpu_run", 32'(cpu_run), 32'd1);
    check_eq("t1_busy_done", 32'(busy), 32'd0);
    check_eq("t1_words", 32'(words_loaded), 32'd2);
    check_eq("t1_wr_en_low", 32'(wr_en), 32'd0);
    check_eq("t1_wr_addr_hold", 32'(wr_addr), 32'd1);
    check_eq("t1_write_count", 32'(wr_cnt - base), 32'd2);

    // Restart from DONE with a one-word reload
    base = wr_cnt;
    pulse_start();
    check_eq("t2_cpu_drop", 32'(cpu_run), 32'd0);
    check_eq("t2_busy", 32'(busy), 32'd1);
    check_eq("t2_words_clr", 32'(words_loaded), 32'd0);
    send_byte(8'h01);
    send_word(32'h12345678);
    check_eq("t2_addr", 32'(wr_addr), 32'd0);
    check_eq("t2_data", wr_data, 32'h12345678);
    finish_load(8'h08);
    check_eq("t2_words", 32'(words_loaded), 32'd1);
    check_eq("t2_cpu_run", 32'(cpu_run), 32'd1);
    check_eq("t2_write_count", 32'(wr_cnt - base), 32'd1);

    // Oversized count aborts
    base = wr_cnt;
    pulse_start();
    send_byte(8'h41);
    check_eq("t3_error", 32'(error), 32'd1);
    check_eq("t3_rx_ready", 32'(rx_ready), 32'd0);
    check_eq("t3_busy", 32'(busy), 32'd0);
    check_eq("t3_cpu_run", 32'(cpu_run), 32'd0);
    repeat (3) idle_cycle();
    check_eq("t3_error_sticky", 32'(error), 32'd1);
    check_eq("t3_no_write", 32'(wr_cnt - base), 32'd0);

    // Zero count from ERROR goes straight to DONE
    base = wr_cnt;
    pulse_start();
    check_eq("t4_error_clr", 32'(error), 32'd0);
    send_byte(8'h00);
    check_eq("t4_cpu_run", 32'(cpu_run), 32'd1);
    check_eq("t4_busy", 32'(busy), 32'd0);
    check_eq("t4_words", 32'(words_loaded), 32'd0);
    idle_cycle();
    check_eq("t4_no_write", 32'(wr_cnt - base), 32'd0);

    // Throttled stream with a start pulse in the middle of a word
    base = wr_cnt;
    pulse_start();
    send_byte(8'h02);
    send_byte(8'hD4); idle_cycle();
    send_byte(8'hC3);
    pulse_start();
    check_eq("t5_start_ignored_busy", 32'(busy), 32'd1);
    send_byte(8'hB2); idle_cycle();
    send_byte(8'hA1);
    check_eq("t5_w0_wr_en", 32'(wr_en), 32'd1);
    check_eq("t5_w0_data", wr_data, 32'hA1B2C3D4);
    idle_cycle();
    send_byte(8'h3C); idle_cycle();
    send_byte(8'h2D); idle_cycle();
    send_byte(8'h1E); idle_cycle();
    send_byte(8'h0F);
    check_eq("t5_w1_addr", 32'(wr_addr), 32'd1);
    check_eq("t5_w1_data", wr_data, 32'h0F1E2D3C);
    finish_load(8'h04);
    check_eq("t5_cpu_run", 32'(cpu_run), 32'd1);
    check_eq("t5_words", 32'(words_loaded), 32'd2);
    check_eq("t5_write_count", 32'(wr_cnt - base), 32'd2);
    check_eq("t5_mem0", mem_model[0], 32'hA1B2C3D4);
    check_eq("t5_mem1", mem_model[1], 32'h0F1E2D3C);

    // Reset in the middle of word 1
    pulse_start();
    send_byte(8'h02);
    send_word(32'hDDCCBBAA);
    idle_cycle();
    send_byte(8'hEE);
    send_byte(8'hFF);
    base = wr_cnt;
    #2 reset = 1'b1;
    #1;
    check_eq("t6_rx_ready", 32'(rx_ready), 32'd0);
    check_eq("t6_wr_en", 32'(wr_en), 32'd0);
    check_eq("t6_busy", 32'(busy), 32'd0);
    check_eq("t6_words", 32'(words_loaded), 32'd0);
    check_eq("t6_wr_data", wr_data, 32'd0);
    check_eq("t6_cpu_run", 32'(cpu_run), 32'd0);
    check_eq("t6_error", 32'(error), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    pulse_start();
    send_byte(8'h01);
    send_word(32'h44332211);
    check_eq("t6_addr", 32'(wr_addr), 32'd0);
    check_eq("t6_data", wr_data, 32'h44332211);
    finish_load(8'h44);
    check_eq("t6_cpu_run_after", 32'(cpu_run), 32'd1);
    check_eq("t6_write_count", 32'(wr_cnt - base), 32'd1);
    check_eq("t6_mem0", mem_model[0], 32'h44332211);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Bad checksum keeps the words but holds the core
    base = wr_cnt;
    pulse_start();
    send_byte(8'h02);
    send_word(32'h00007033);
    send_word(32'h00100093);
    send_byte(8'hC1);
    check_eq("t7_error", 32'(error), 32'd1);
    check_eq("t7_cpu_run", 32'(cpu_run), 32'd0);
    check_eq("t7_write_count", 32'(wr_cnt - base), 32'd2);
    check_eq("t7_mem1", mem_model[1], 32'h00100093);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
